// File: rtl/fft_result_reader_if.sv
// Output stream of the FFT result reader: {I,Q} word, natural bin index and last flag under valid/ready.
// Optional magnitude field m_mag exists only when FFT_READER_MAG_EN is defined.
interface fft_result_reader_if #(
    parameter int N          = 64,
    parameter int DATA_WIDTH = 8
);
    localparam int AW = $clog2(N);

    logic                    m_valid;
    logic                    m_ready;
    logic [2*DATA_WIDTH-1:0] m_data;
    logic [AW-1:0]           m_index;
    logic                    m_last;
`ifdef FFT_READER_MAG_EN
    logic [2*DATA_WIDTH:0]   m_mag;
`endif

    modport master (
        input  m_ready,
        output m_valid,
        output m_data,
        output m_index,
`ifdef FFT_READER_MAG_EN
        output m_mag,
`endif
        output m_last
    );

    modport slave (
        output m_ready,
        input  m_valid,
        input  m_data,
        input  m_index,
`ifdef FFT_READER_MAG_EN
        input  m_mag,
`endif
        input  m_last
    );
endinterface

// File: rtl/fft_result_reader.sv
// Drains an N-point FFT result from the ping-pong result RAM in natural bin order through a 4-entry FIFO.
// Optional feature macro: FFT_READER_MAG_EN adds m_mag = I*I + Q*Q carried alongside each word.
module fft_result_reader #(
    parameter int N           = 64,
    parameter int DATA_WIDTH  = 8,
    parameter int BIT_REVERSE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    bank_sel,
    output logic                    busy,
    output logic                    done,
    output logic                    ram_en,
    output logic                    ram_sel,
    output logic [$clog2(N)-1:0]    ram_addr,
    input  logic [2*DATA_WIDTH-1:0] ram_dout,
    fft_result_reader_if.master     m
);
    localparam int AW    = $clog2(N);
    localparam int WW    = 2 * DATA_WIDTH;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [WW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
`ifdef FFT_READER_MAG_EN
        logic [WW:0]   mag;
`endif
    } entry_t;

    function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = k[AW-1-i];
        end
        return (BIT_REVERSE != 0) ? r : k;
    endfunction

`ifdef FFT_READER_MAG_EN
    function automatic logic [WW:0] mag_of(input logic [WW-1:0] w);
        logic signed [DATA_WIDTH-1:0] i_s;
        logic signed [DATA_WIDTH-1:0] q_s;
        logic signed [WW-1:0]         ii;
        logic signed [WW-1:0]         qq;
        i_s = w[WW-1:DATA_WIDTH];
        q_s = w[DATA_WIDTH-1:0];
        ii  = i_s * i_s;
        qq  = q_s * q_s;
        return {1'b0, ii} + {1'b0, qq};
    endfunction
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ram_en_q, ram_en_d;
    logic          ram_sel_q, ram_sel_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [AW-1:0] issue_idx_q, issue_idx_d;
    logic          rdp_q, rdp_d;
    logic [AW-1:0] rdp_idx_q, rdp_idx_d;
    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [2:0]    count_q, count_d;
    logic          valid_q, valid_d;

    logic          pop_s;
    logic          credit_s;
    logic [2:0]    count_eff_s;
    entry_t        new_entry_s;

    // FIFO: pops shift toward the head so the head entry is always slot 0
    always_comb begin
        pop_s            = valid_q && m.m_ready;
        count_eff_s      = count_q - {2'b00, pop_s};
        new_entry_s.data = ram_dout;
        new_entry_s.idx  = rdp_idx_q;
        new_entry_s.last = (rdp_idx_q == AW'(N - 1));
`ifdef FFT_READER_MAG_EN
        new_entry_s.mag  = mag_of(ram_dout);
`endif
        for (int i = 0; i < DEPTH - 1; i++) begin
            fifo_d[i] = pop_s ? fifo_q[i+1] : fifo_q[i];
        end
        fifo_d[DEPTH-1] = pop_s ? '0 : fifo_q[DEPTH-1];
        if (rdp_q) begin
            fifo_d[count_eff_s[1:0]] = new_entry_s;
            count_d                  = count_eff_s + 3'd1;
        end else begin
            count_d = count_eff_s;
        end
        valid_d  = (count_d != 3'd0);
        // reads already in flight will land in the FIFO, so they consume credit now
        credit_s = (count_eff_s + {2'b00, ram_en_q} + {2'b00, rdp_q}) < 3'd4;
    end

    // Drain FSM: read issue, bank latch and completion
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ram_en_d    = 1'b0;
        ram_sel_d   = ram_sel_q;
        ram_addr_d  = ram_addr_q;
        issue_idx_d = issue_idx_q;
        rdp_d       = ram_en_q;
        rdp_idx_d   = issue_idx_q;
        case (state_q)
            S_IDLE: begin
                // bin 0 is issued on the start edge itself to reach the two-cycle first-word latency
                if (start) begin
                    ram_sel_d   = bank_sel;
                    busy_d      = 1'b1;
                    ram_en_d    = 1'b1;
                    ram_addr_d  = rd_addr({AW{1'b0}});
                    issue_idx_d = {AW{1'b0}};
                    k_d         = AW'(1);
                    state_d     = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (credit_s) begin
                    ram_en_d    = 1'b1;
                    ram_addr_d  = rd_addr(k_q);
                    issue_idx_d = k_q;
                    k_d         = k_q + AW'(1);
                    if (k_q == AW'(N - 1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    ram_en_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (pop_s && fifo_q[0].last) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    k_d     = {AW{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= {AW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_sel_q   <= 1'b0;
            ram_addr_q  <= {AW{1'b0}};
            issue_idx_q <= {AW{1'b0}};
            rdp_q       <= 1'b0;
            rdp_idx_q   <= {AW{1'b0}};
            count_q     <= 3'd0;
            valid_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_en_q    <= ram_en_d;
            ram_sel_q   <= ram_sel_d;
            ram_addr_q  <= ram_addr_d;
            issue_idx_q <= issue_idx_d;
            rdp_q       <= rdp_d;
            rdp_idx_q   <= rdp_idx_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_en    = ram_en_q;
    assign ram_sel   = ram_sel_q;
    assign ram_addr  = ram_addr_q;
    assign m.m_valid = valid_q;
    assign m.m_data  = fifo_q[0].data;
    assign m.m_index = fifo_q[0].idx;
    assign m.m_last  = fifo_q[0].last;
`ifdef FFT_READER_MAG_EN
    assign m.m_mag   = fifo_q[0].mag;
`endif
endmodule
